// File: rtl/kf8237_channel_arbiter_if.sv
// Handshake and command bus between the 8237 channel arbiter (slave side)
// and its environment: request pins, command bits, HRQ/HLDA and DACK.
interface kf8237_channel_arbiter_if;
    logic       master_clear;
    logic [3:0] dma_request;
    logic       dreq_sense_active_low;
    logic       controller_disable;
    logic       rotating_priority;
    logic [3:0] mask_register;
    logic [3:0] request_register;
    logic       hold_acknowledge;
    logic       transfer_done;
    logic       hold_request;
    logic [3:0] dma_acknowledge;
    logic [1:0] active_channel;
    logic       service_start;
    logic [3:0] clear_software_request;

    modport master (
        output master_clear, dma_request, dreq_sense_active_low, controller_disable,
               rotating_priority, mask_register, request_register, hold_acknowledge,
               transfer_done,
        input  hold_request, dma_acknowledge, active_channel, service_start,
               clear_software_request
    );

    modport slave (
        input  master_clear, dma_request, dreq_sense_active_low, controller_disable,
               rotating_priority, mask_register, request_register, hold_acknowledge,
               transfer_done,
        output hold_request, dma_acknowledge, active_channel, service_start,
               clear_software_request
    );
endinterface

// File: rtl/kf8237_channel_arbiter.sv
// 8237-style DMA channel arbiter: request conditioning, priority select and HRQ/HLDA/DACK
// sequencing. Rotating priority is built only when KF8237_ROTATING_PRIORITY_EN is defined.
module kf8237_channel_arbiter (
    input  logic                    clock,
    input  logic                    reset,
    kf8237_channel_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, HOLD_REQ, SERVICE, RELEASE} state_t;

    state_t     state, state_next;
    logic [3:0] eff;
    logic [1:0] active_q, active_next;
    logic [3:0] dack_q, dack_next;
    logic       start_q, start_next;
    logic [3:0] clr_q, clr_next;
    logic [1:0] base;
    logic [1:0] winner;

    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            eff <= 4'b0000;
        end else if (bus.master_clear) begin
            eff <= 4'b0000;
        end else begin
            eff <= ((bus.dma_request ^ {4{bus.dreq_sense_active_low}}) & ~bus.mask_register)
                   | bus.request_register;
        end
    end

`ifdef KF8237_ROTATING_PRIORITY_EN
    logic [1:0] rot_ptr, rot_next;

    assign base = bus.rotating_priority ? rot_ptr : 2'd0;

    // The channel after the one just completed becomes highest priority.
    always_comb begin
        rot_next = rot_ptr;
        if (!bus.rotating_priority) begin
            rot_next = 2'd0;
        end else if (state == SERVICE && bus.transfer_done) begin
            rot_next = active_q + 2'd1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rot_ptr <= 2'd0;
        end else if (bus.master_clear) begin
            rot_ptr <= 2'd0;
        end else begin
            rot_ptr <= rot_next;
        end
    end
`else
    logic unused_rotating_priority;

    assign unused_rotating_priority = bus.rotating_priority;
    assign base = 2'd0;
`endif

    // Scan from lowest to highest priority so the last hit is the winner.
    always_comb begin
        winner = base;
        for (int i = 3; i >= 0; i--) begin
            if (eff[base + 2'(i)]) begin
                winner = base + 2'(i);
            end
        end
    end

    // NOTE: every output of this block gets a default first, so no path infers a latch.
    always_comb begin
        state_next  = state;
        active_next = active_q;
        dack_next   = dack_q;
        start_next  = 1'b0;
        clr_next    = 4'b0000;
        case (state)
            IDLE: begin
                if (|eff && !bus.controller_disable) begin
                    state_next  = HOLD_REQ;
                    active_next = winner;
                end
            end
            HOLD_REQ: begin
                if (bus.hold_acknowledge) begin
                    state_next = SERVICE;
                    dack_next  = 4'b0001 << active_q;
                    start_next = 1'b1;
                end else if (!eff[active_q]) begin
                    state_next = IDLE;
                end
            end
            SERVICE: begin
                if (bus.transfer_done) begin
                    state_next = RELEASE;
                    dack_next  = 4'b0000;
                    clr_next   = 4'b0001 << active_q;
                end
            end
            RELEASE: begin
                if (!bus.hold_acknowledge) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            active_q <= 2'd0;
            dack_q   <= 4'b0000;
            start_q  <= 1'b0;
            clr_q    <= 4'b0000;
        end else if (bus.master_clear) begin
            state    <= IDLE;
            active_q <= 2'd0;
            dack_q   <= 4'b0000;
            start_q  <= 1'b0;
            clr_q    <= 4'b0000;
        end else begin
            state    <= state_next;
            active_q <= active_next;
            dack_q   <= dack_next;
            start_q  <= start_next;
            clr_q    <= clr_next;
        end
    end

    assign bus.hold_request           = (state == HOLD_REQ) || (state == SERVICE);
    assign bus.dma_acknowledge        = dack_q;
    assign bus.active_channel         = active_q;
    assign bus.service_start          = start_q;
    assign bus.clear_software_request = clr_q;
endmodule

// File: tb/tb_kf8237_channel_arbiter.sv
// Self-checking bench for kf8237_channel_arbiter: directed scenarios plus randomized
// services checked against a transaction-level priority model.
module tb_kf8237_channel_arbiter;
    logic clock;
    logic reset;
    int   checks;
    int   errors;

`ifdef KF8237_ROTATING_PRIORITY_EN
    localparam bit ROT_EN = 1'b1;
`else
    localparam bit ROT_EN = 1'b0;
`endif

    // Model state: which channel currently has top priority, and whether rotation is on.
    logic [1:0] model_ptr;
    bit         rot_mode;

    kf8237_channel_arbiter_if bus ();

    kf8237_channel_arbiter dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] model_eff();
        return ((bus.dma_request ^ {4{bus.dreq_sense_active_low}}) & ~bus.mask_register)
               | bus.request_register;
    endfunction

    function automatic logic [1:0] predict(input logic [3:0] e);
        int start;
        start = (ROT_EN && rot_mode) ? int'(model_ptr) : 0;
        for (int i = 0; i < 4; i++) begin
            if (e[(start + i) % 4]) return 2'((start + i) % 4);
        end
        return 2'd0;
    endfunction

    task automatic apply(input logic [3:0] dreq, input logic [3:0] mask, input logic [3:0] req,
                         input bit sense, input bit rot);
        bus.dma_request           = dreq;
        bus.mask_register         = mask;
        bus.request_register      = req;
        bus.dreq_sense_active_low = sense;
        bus.rotating_priority     = rot;
        rot_mode                  = rot;
        if (!rot) model_ptr = 2'd0;
    endtask

    // Waits for HRQ, checks the granted channel, raises HLDA and checks entry to SERVICE.
    task automatic enter_service(input int hlda_delay, output logic [1:0] exp_ch);
        int n;
        exp_ch = predict(model_eff());
        n = 0;
        while (bus.hold_request !== 1'b1 && n < 12) begin
            @(negedge clock);
            n++;
        end
        check("hrq_wait", bus.hold_request, 1);
        check("arb_channel", bus.active_channel, exp_ch);
        check("dack_in_hold", bus.dma_acknowledge, 0);
        repeat (hlda_delay) @(negedge clock);
        bus.hold_acknowledge = 1'b1;
        @(negedge clock);
        check("dack_service", bus.dma_acknowledge, 4'b0001 << exp_ch);
        check("service_start", bus.service_start, 1);
    endtask

    // Completes the service, checks RELEASE holds off while HLDA stays high, returns to IDLE.
    task automatic finish_service(input logic [1:0] ch, input bit clean);
        @(negedge clock);
        check("start_pulse", bus.service_start, 0);
        check("hrq_service", bus.hold_request, 1);
        bus.transfer_done = 1'b1;
        @(negedge clock);
        bus.transfer_done = 1'b0;
        check("dack_release", bus.dma_acknowledge, 0);
        check("clr_pulse", bus.clear_software_request, 4'b0001 << ch);
        check("hrq_release", bus.hold_request, 0);
        model_ptr = (ROT_EN && rot_mode) ? ch + 2'd1 : 2'd0;
        if (clean) begin
            bus.mask_register    = 4'hF;
            bus.request_register = 4'h0;
        end
        @(negedge clock);
        check("clr_width", bus.clear_software_request, 0);
        check("release_wait", bus.hold_request, 0);
        bus.hold_acknowledge = 1'b0;
        @(negedge clock);
    endtask

    initial begin
        logic [1:0] ch;
        logic [3:0] r_dreq, r_mask, r_req;
        bit         r_sense, r_rot;

        checks = 0;
        errors = 0;
        model_ptr = 2'd0;
        rot_mode  = 1'b0;
        reset = 1'b1;
        bus.master_clear       = 1'b0;
        bus.controller_disable = 1'b0;
        bus.hold_acknowledge   = 1'b0;
        bus.transfer_done      = 1'b0;
        apply(4'h0, 4'h0, 4'h0, 1'b0, 1'b0);

        // Reset state
        repeat (2) @(negedge clock);
        check("rst_hrq", bus.hold_request, 0);
        check("rst_dack", bus.dma_acknowledge, 0);
        check("rst_active", bus.active_channel, 0);
        check("rst_start", bus.service_start, 0);
        check("rst_clr", bus.clear_software_request, 0);
        reset = 1'b0;
        @(negedge clock);

        // HLDA in IDLE is ignored
        bus.hold_acknowledge = 1'b1;
        repeat (3) @(negedge clock);
        check("hlda_idle_hrq", bus.hold_request, 0);
        check("hlda_idle_dack", bus.dma_acknowledge, 0);
        bus.hold_acknowledge = 1'b0;
        @(negedge clock);

        // DREQ=0100: HRQ two clocks later, transfer_done ignored in HOLD_REQ, late HLDA
        apply(4'b0100, 4'h0, 4'h0, 1'b0, 1'b0);
        @(negedge clock);
        check("hrq_latency1", bus.hold_request, 0);
        @(negedge clock);
        check("hrq_latency2", bus.hold_request, 1);
        check("ch2_active", bus.active_channel, 2);
        bus.transfer_done = 1'b1;
        @(negedge clock);
        bus.transfer_done = 1'b0;
        @(negedge clock);
        check("tdone_ignored_hrq", bus.hold_request, 1);
        check("tdone_ignored_clr", bus.clear_software_request, 0);
        bus.hold_acknowledge = 1'b1;
        @(negedge clock);
        check("ch2_dack", bus.dma_acknowledge, 4'b0100);
        check("ch2_start", bus.service_start, 1);
        check("ch2_active_svc", bus.active_channel, 2);
        // Input changes during SERVICE must not disturb the grant
        bus.dma_request        = 4'b0001;
        bus.mask_register      = 4'b0100;
        bus.controller_disable = 1'b1;
        repeat (2) @(negedge clock);
        check("svc_stable_dack", bus.dma_acknowledge, 4'b0100);
        check("svc_stable_active", bus.active_channel, 2);
        bus.controller_disable = 1'b0;
        finish_service(2'd2, 1'b1);

        // Fixed priority, DREQ=1011 held: channel 0 every time
        apply(4'b1011, 4'h0, 4'h0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            enter_service(1, ch);
            check("fixed_ch0", bus.active_channel, 0);
            finish_service(ch, i == 3);
        end

        // Rotating priority, DREQ=1111 held: 0,1,2,3,0 (all 0 when the feature is absent)
        apply(4'b1111, 4'h0, 4'h0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            enter_service(0, ch);
            check("rotation_order", bus.active_channel, ROT_EN ? (i % 4) : 0);
            finish_service(ch, i == 4);
        end
        apply(4'h0, 4'hF, 4'h0, 1'b0, 1'b0);
        @(negedge clock);

        // Request drops in HOLD_REQ before HLDA: back to IDLE, DACK never asserted
        apply(4'b0010, 4'h0, 4'h0, 1'b0, 1'b0);
        repeat (2) @(negedge clock);
        check("drop_hrq_up", bus.hold_request, 1);
        bus.dma_request = 4'b0000;
        @(negedge clock);
        check("drop_hrq_hold", bus.hold_request, 1);
        @(negedge clock);
        check("drop_hrq_low", bus.hold_request, 0);
        repeat (3) @(negedge clock);
        check("drop_no_dack", bus.dma_acknowledge, 0);
        check("drop_stay_idle", bus.hold_request, 0);

        // Request drop and HLDA in the same cycle: HLDA wins
        apply(4'b0010, 4'h0, 4'h0, 1'b0, 1'b0);
        repeat (2) @(negedge clock);
        bus.dma_request = 4'b0000;
        @(negedge clock);
        bus.hold_acknowledge = 1'b1;
        @(negedge clock);
        check("hlda_wins_dack", bus.dma_acknowledge, 4'b0010);
        check("hlda_wins_start", bus.service_start, 1);
        finish_service(2'd1, 1'b1);

        // Masked DREQ but software request set: ch0 served, software bit cleared
        apply(4'b0001, 4'b0001, 4'b0001, 1'b0, 1'b0);
        enter_service(2, ch);
        finish_service(ch, 1'b1);

        // Controller disable blocks arbitration in IDLE
        bus.controller_disable = 1'b1;
        apply(4'b0001, 4'h0, 4'h0, 1'b0, 1'b0);
        repeat (4) @(negedge clock);
        check("disable_no_hrq", bus.hold_request, 0);
        bus.controller_disable = 1'b0;
        enter_service(0, ch);
        finish_service(ch, 1'b1);

        // Active-low DREQ sense
        apply(4'b1101, 4'h0, 4'h0, 1'b1, 1'b0);
        enter_service(1, ch);
        check("sense_low_ch1", bus.active_channel, 1);
        finish_service(ch, 1'b1);

        // Randomized services against the priority model
        for (int i = 0; i < 24; i++) begin
            r_dreq  = 4'($urandom_range(0, 15));
            r_mask  = 4'($urandom_range(0, 15));
            r_req   = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
            r_sense = 1'($urandom_range(0, 1));
            r_rot   = 1'($urandom_range(0, 1));
            apply(r_dreq, r_mask, r_req, r_sense, r_rot);
            if (model_eff() == 4'h0) begin
                repeat (4) @(negedge clock);
                check("rand_no_request", bus.hold_request, 0);
            end else begin
                enter_service(int'($urandom_range(0, 3)), ch);
                finish_service(ch, 1'b1);
            end
        end

        // master_clear resets the rotation pointer
        apply(4'b0001, 4'h0, 4'h0, 1'b0, 1'b1);
        enter_service(0, ch);
        finish_service(ch, 1'b1);
        bus.master_clear = 1'b1;
        @(negedge clock);
        bus.master_clear = 1'b0;
        model_ptr = 2'd0;
        apply(4'b1111, 4'h0, 4'h0, 1'b0, 1'b1);
        enter_service(0, ch);
        check("mclr_ptr_ch0", bus.active_channel, 0);
        finish_service(ch, 1'b1);

        // master_clear during SERVICE on ch3: synchronous
        apply(4'b1000, 4'h0, 4'h0, 1'b0, 1'b0);
        enter_service(0, ch);
        bus.master_clear = 1'b1;
        bus.dma_request  = 4'b0000;
        #1;
        check("mclr_sync_hrq", bus.hold_request, 1);
        check("mclr_sync_dack", bus.dma_acknowledge, 4'b1000);
        @(negedge clock);
        check("mclr_hrq", bus.hold_request, 0);
        check("mclr_dack", bus.dma_acknowledge, 0);
        check("mclr_active", bus.active_channel, 0);
        bus.master_clear     = 1'b0;
        bus.hold_acknowledge = 1'b0;
        model_ptr = 2'd0;
        repeat (2) @(negedge clock);
        check("mclr_idle", bus.hold_request, 0);

        // reset during SERVICE on ch3: asynchronous
        apply(4'b1000, 4'h0, 4'h0, 1'b0, 1'b0);
        enter_service(0, ch);
        #2;
        reset = 1'b1;
        #1;
        check("arst_hrq", bus.hold_request, 0);
        check("arst_dack", bus.dma_acknowledge, 0);
        check("arst_active", bus.active_channel, 0);
        bus.dma_request      = 4'b0000;
        bus.hold_acknowledge = 1'b0;
        model_ptr = 2'd0;
        @(negedge clock);
        reset = 1'b0;
        repeat (3) @(negedge clock);
        check("arst_idle", bus.hold_request, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/kf8237_channel_arbiter.md
KF8237_CHANNEL_ARBITER -- requirements
Module: kf8237_channel_arbiter

Interface
REQ-001 The block SHALL provide the following ports, one per line: name, direction, width, meaning.
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- master_clear  in  1  synchronous software reset pulse
- dma_request  in  4  DREQ pins, channel n on bit n
- dreq_sense_active_low  in  1  command bit 6; when 1, DREQ is active-low
- controller_disable  in  1  command bit 2; when 1, no new arbitration
- rotating_priority  in  1  command bit 4; when 1, rotating priority
- mask_register  in  4  when bit n is 1, channel n is masked
- request_register  in  4  software requests, not maskable
- hold_acknowledge  in  1  HLDA from the bus owner
- transfer_done  in  1  one-cycle pulse from the transfer engine; the service is complete
- hold_request  out  1  HRQ to the bus owner
- dma_acknowledge  out  4  DACK, active-high, one-hot or zero
- active_channel  out  2  encoded channel being serviced
- service_start  out  1  one-cycle pulse on entry to SERVICE
- clear_software_request  out  4  one-cycle pulse on completion of a channel's service

Function
REQ-002 The registered effective request SHALL be eff[n] = ((dma_request[n] ^ dreq_sense_active_low) & ~mask_register[n]) | request_register[n], with a latency of one clock.
REQ-003 The block SHALL implement exactly four states: IDLE, HOLD_REQ, SERVICE and RELEASE.
REQ-004 IDLE: when any eff bit is set and controller_disable is 0, the block SHALL latch the highest-priority requesting channel into active_channel and enter HOLD_REQ on the next clock.
REQ-005 hold_request SHALL be 1 exactly in the states HOLD_REQ and SERVICE.
REQ-006 HOLD_REQ: when hold_acknowledge is 1, the block SHALL enter SERVICE, set dma_acknowledge[active_channel] on the same transition, and pulse service_start for one clock.
REQ-007 HOLD_REQ: when eff[active_channel] drops before hold_acknowledge, the block SHALL return to IDLE and drop hold_request; no rotation update SHALL occur.
REQ-008 HOLD_REQ: when eff[active_channel] drops and hold_acknowledge rises in the same cycle, hold_acknowledge SHALL take precedence and the block SHALL enter SERVICE.
REQ-009 SERVICE: changes to DREQ, mask, disable or priority SHALL NOT alter active_channel or dma_acknowledge.
REQ-010 SERVICE: on transfer_done the block SHALL enter RELEASE, clear dma_acknowledge, pulse clear_software_request[active_channel], and update priority.
REQ-011 RELEASE: the block SHALL wait for hold_acknowledge to be 0, then enter IDLE; it SHALL NOT re-arbitrate in the same cycle.
REQ-012 Fixed priority SHALL be ch0 > ch1 > ch2 > ch3.
REQ-013 Rotating priority: after channel k completes service, channel (k+1) mod 4 SHALL have the highest priority and k the lowest, with 2-bit wrap-around from 3 to 0.
REQ-014 When rotating_priority is 0, the priority SHALL revert to fixed immediately, and the rotation pointer SHALL reset to ch0.
REQ-015 transfer_done SHALL be ignored outside SERVICE.
REQ-016 A hold_acknowledge of 1 SHALL be ignored in IDLE.
REQ-017 master_clear SHALL have the same effect as reset but act synchronously, and it SHALL take precedence over every other input in any state, including mid-service.

Reset
REQ-018 On reset the block SHALL enter IDLE with hold_request=0, dma_acknowledge=0000, active_channel=00, service_start=0, clear_software_request=0000, eff=0000 and the rotation pointer at ch0.
REQ-019 Reset asserted mid-service SHALL drop hold_request and DACK immediately and asynchronously.

Configuration
REQ-020 The macro KF8237_ROTATING_PRIORITY_EN SHALL control the rotating-priority feature.
- Defined: rotating priority SHALL be implemented per REQ-013 and REQ-014.
- Undefined: the rotation pointer logic SHALL be omitted, rotating_priority SHALL be ignored, and priority SHALL always be fixed per REQ-012.

Verification
REQ-021 A bench SHALL cover the following directed scenarios.
- DREQ=0100, sense high, mask=0, HLDA raised 3 clocks after HRQ -> HRQ 2 clocks after DREQ; DACK=0100, active_channel=2 and a service_start pulse in the cycle after HLDA.
- DREQ=1011 held, fixed priority, four services -> channel 0 is served every time.
- rotating_priority=1, DREQ=1111 held, four services -> order 0,1,2,3 then 0. Run the same stimulus with the macro undefined -> 0,0,0,0.
- DREQ=0010, then drop it while in HOLD_REQ before HLDA -> return to IDLE, HRQ=0, DACK never asserted.
- mask=0001, DREQ=0001, request_register=0001 -> ch0 is serviced; transfer_done -> clear_software_request=0001 for one clock.
- Assert master_clear and, separately, reset during SERVICE on ch3 -> HRQ=0, DACK=0000, IDLE; master_clear takes effect on the next edge, reset asynchronously.
